// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// The master side issues operands; the slave side returns registered results.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, carry, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, carry, overflow
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, one bit per clock, LSB first.
// Subtraction is A + ~B + 1; the carry register is preloaded with the +1.
//
// state | meaning
// IDLE  | waiting for start; operands are sampled on the start edge
// RUN   | one full-adder step per edge, WIDTH steps in total
// DONE  | one-cycle done pulse; results stay held until the next DONE entry
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_out;

  assign s_bit = sa[0] ^ sb[0] ^ cy;
  assign c_out = (sa[0] & sb[0]) | (cy & (sa[0] ^ sb[0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sa           <= '0;
      sb           <= '0;
      res          <= '0;
      cy           <= 1'b0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.sum      <= '0;
      bus.carry    <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa       <= bus.a;
            sb       <= bus.sub ? ~bus.b : bus.b;
            cy       <= bus.sub;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          res <= {s_bit, res[WIDTH-1:1]};
          cy  <= c_out;
          cnt <= cnt + CW'(1);
          // On the MSB step cy is the carry into the MSB, c_out the carry out of it.
          if (cnt == CW'(WIDTH - 1)) begin
            bus.sum      <= {s_bit, res[WIDTH-1:1]};
            bus.carry    <= c_out;
            bus.overflow <= cy ^ c_out;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=2.
// Expected results are queued at stimulus time and popped when done pulses.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8();
  serial_adder_if #(.WIDTH(2)) bus2();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  res_t q8[$];
  res_t q2[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   overlap = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic sub);
    logic [32:0] mask, aa, bb, full;
    res_t r;
    mask    = (33'd1 << w) - 33'd1;
    aa      = {1'b0, a} & mask;
    bb      = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    full    = aa + bb + {32'd0, sub};
    r.sum   = full[31:0] & mask[31:0];
    r.carry = full[w];
    r.ovf   = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
    return r;
  endfunction

  // Scoreboard monitors: every done pulse must match the oldest queued result.
  initial begin
    res_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus8.busy && bus8.done) overlap = 1'b1;
      if (bus2.busy && bus2.done) overlap = 1'b1;
      if (bus8.done) begin
        if (q8.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done8_unexpected: got done=1 expected no pending operation");
        end else begin
          e = q8.pop_front();
          check("sum8", 32'(bus8.sum), e.sum);
          check("carry8", 32'(bus8.carry), 32'(e.carry));
          check("ovf8", 32'(bus8.overflow), 32'(e.ovf));
        end
      end
      if (bus2.done) begin
        if (q2.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done2_unexpected: got done=1 expected no pending operation");
        end else begin
          e = q2.pop_front();
          check("sum2", 32'(bus2.sum), e.sum);
          check("carry2", 32'(bus2.carry), 32'(e.carry));
          check("ovf2", 32'(bus2.overflow), 32'(e.ovf));
        end
      end
    end
  end

  task automatic wait_idle8();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (!bus8.busy && !bus8.done) ok = 1'b1;
    end
    if (!ok) fail_now("idle8_wait");
  endtask

  task automatic wait_idle2();
    bit ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (!bus2.busy && !bus2.done) ok = 1'b1;
    end
    if (!ok) fail_now("idle2_wait");
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sub, input res_t exp);
    bit got = 1'b0;
    wait_idle8();
    bus8.a     = a;
    bus8.b     = b;
    bus8.sub   = sub;
    bus8.start = 1'b1;
    q8.push_back(exp);
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus8.done) begin
        got = 1'b1;
        check("latency8", i, 8);
      end
    end
    if (!got) fail_now("done8_wait");
  endtask

  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic sub, input res_t exp);
    bit got = 1'b0;
    wait_idle2();
    bus2.a     = a;
    bus2.b     = b;
    bus2.sub   = sub;
    bus2.start = 1'b1;
    q2.push_back(exp);
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (bus2.done) begin
        got = 1'b1;
        check("latency2", i, 2);
      end
    end
    if (!got) fail_now("done2_wait");
  endtask

  vec_t tbl[9];

  initial begin
    res_t e;
    int   busyc, dones;
    int   dpos[$];
    logic [7:0] ra, rb;
    logic       rs;

    tbl = '{
      '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0},
      '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
      '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
      '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0},
      '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1},
      '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
      '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0},
      '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1},
      '{8'h3C, 8'h5A, 1'b1, 8'hE2, 1'b0, 1'b0}
    };

    rst = 1'b1;
    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0;
    bus2.start = 1'b0; bus2.sub = 1'b0; bus2.a = '0; bus2.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus8.busy), 0);
    check("rst_done", 32'(bus8.done), 0);
    check("rst_sum", 32'(bus8.sum), 0);
    check("rst_carry", 32'(bus8.carry), 0);
    check("rst_ovf", 32'(bus8.overflow), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      e = '{32'(tbl[i].sum), tbl[i].carry, tbl[i].ovf};
      run8(tbl[i].a, tbl[i].b, tbl[i].sub, e);
    end

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      run8(ra, rb, rs, model(8, 32'(ra), 32'(rb), rs));
    end

    // Start re-pulsed during RUN must be ignored.
    wait_idle8();
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.sub = 1'b0; bus8.start = 1'b1;
    q8.push_back('{32'h30, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    busyc = int'(bus8.busy);
    dones = int'(bus8.done);
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      bus8.start = (i == 3);
      bus8.a     = (i == 3) ? 8'hAA : 8'h10;
      bus8.b     = (i == 3) ? 8'h55 : 8'h20;
      @(posedge clk);
      #1;
      busyc += int'(bus8.busy);
      dones += int'(bus8.done);
    end
    check("repulse_busy_cycles", busyc, 8);
    check("repulse_done_count", dones, 1);

    // Start held high: one operation every WIDTH+2 cycles.
    wait_idle8();
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.sub = 1'b0; bus8.start = 1'b1;
    repeat (3) q8.push_back('{32'h46, 1'b0, 1'b0});
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus8.done) dpos.push_back(i);
    end
    @(negedge clk);
    bus8.start = 1'b0;
    check("b2b_done_count", dpos.size(), 3);
    if (dpos.size() == 3) begin
      check("b2b_first_done", dpos[0], 8);
      check("b2b_period_1", dpos[1] - dpos[0], 10);
      check("b2b_period_2", dpos[2] - dpos[1], 10);
    end

    // Abort mid-operation with asynchronous reset.
    run8(8'h7F, 8'h01, 1'b0, '{32'h80, 1'b0, 1'b1});
    wait_idle8();
    bus8.a = 8'h33; bus8.b = 8'h44; bus8.sub = 1'b0; bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_sum_in_run", 32'(bus8.sum), 32'h80);
    check("hold_ovf_in_run", 32'(bus8.overflow), 1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus8.busy), 0);
    check("abort_done", 32'(bus8.done), 0);
    check("abort_sum", 32'(bus8.sum), 0);
    check("abort_carry", 32'(bus8.carry), 0);
    check("abort_ovf", 32'(bus8.overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      dones += int'(bus8.done);
    end
    check("abort_no_done", dones, 0);
    run8(8'h01, 8'h01, 1'b0, '{32'h02, 1'b0, 1'b0});

    // Exhaustive WIDTH=2 sweep against the reference model.
    for (int av = 0; av < 4; av++)
      for (int bv = 0; bv < 4; bv++)
        for (int sv = 0; sv < 2; sv++)
          run2(2'(av), 2'(bv), 1'(sv), model(2, 32'(av), 32'(bv), 1'(sv)));

    repeat (4) @(posedge clk);
    #1;
    check("busy_done_overlap", 32'(overlap), 0);
    check("q8_drained", q8.size(), 0);
    check("q2_drained", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
